// File: rtl/pipelined_booth_multiplier.sv
// Sequential radix-4 Booth multiplier: one Booth digit per cycle, IDLE/BUSY/DONE handshake.
// Optional early termination when the remaining multiplier digits are all zero: BOOTH_MULT_EARLY_TERM_EN.
module pipelined_booth_multiplier #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [WIDTH-1:0]     Multiplier,
    input  logic [WIDTH-1:0]     Multiplicand,
    input  logic                 Sign,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [2*WIDTH-1:0]   Product,
    output logic                 Busy
);

    localparam int unsigned N    = WIDTH / 2 + 1;
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [2*WIDTH-1:0]   r_mcand;   // multiplicand, pre-shifted by 2i for the current digit
    logic [WIDTH+1:0]     r_mshift;  // extended multiplier, arithmetically shifted by 2i
    logic                 r_prev;    // bit 2i-1 of the extended multiplier
    logic [2*WIDTH-1:0]   r_acc;
    logic [CntW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_product;

    logic [2:0]           w_digit;
    logic [2*WIDTH-1:0]   w_a2;
    logic [2*WIDTH-1:0]   w_pp;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;
    logic                 w_finish;

    assign w_digit    = {r_mshift[1:0], r_prev};
    assign w_a2       = {r_mcand[2*WIDTH-2:0], 1'b0};
    assign w_acc_next = r_acc + w_pp;
    assign w_last     = (r_cnt == CntW'(N - 1));

`ifdef BOOTH_MULT_EARLY_TERM_EN
    logic [WIDTH:0] w_upper;
    logic           w_all_eq;
    // Bits above the current digit's low bit all equal means every later digit is zero.
    assign w_upper  = r_mshift[WIDTH+1:1];
    assign w_all_eq = (w_upper == '0) || (&w_upper);
    assign w_finish = w_last || w_all_eq;
`else
    assign w_finish = w_last;
`endif

    always_comb begin
        w_pp = '0;
        unique case (w_digit)
            3'b001, 3'b010: w_pp = r_mcand;
            3'b011:         w_pp = w_a2;
            3'b100:         w_pp = -w_a2;
            3'b101, 3'b110: w_pp = -r_mcand;
            default:        w_pp = '0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (InValid)  w_state_next = StBusy;
            StBusy:  if (w_finish) w_state_next = StDone;
            StDone:  if (OutReady) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= StIdle;
            r_mcand   <= '0;
            r_mshift  <= '0;
            r_prev    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (InValid) begin
                        r_mcand  <= {{WIDTH{Sign & Multiplicand[WIDTH-1]}}, Multiplicand};
                        r_mshift <= {{2{Sign & Multiplier[WIDTH-1]}}, Multiplier};
                        r_prev   <= 1'b0;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                StBusy: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= {r_mcand[2*WIDTH-3:0], 2'b00};
                    r_mshift <= {{2{r_mshift[WIDTH+1]}}, r_mshift[WIDTH+1:2]};
                    r_prev   <= r_mshift[1];
                    r_cnt    <= r_cnt + CntW'(1);
                    if (w_finish) r_product <= w_acc_next;
                end
                default: ;
            endcase
        end
    end

    assign InReady  = (r_state == StIdle);
    assign Busy     = (r_state == StBusy);
    assign OutValid = (r_state == StDone);
    assign Product  = r_product;

endmodule

// File: tb/tb_pipelined_booth_multiplier.sv
// Self-checking bench for pipelined_booth_multiplier (WIDTH=32) using a result scoreboard.
module tb_pipelined_booth_multiplier;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] Multiplier;
    logic [31:0] Multiplicand;
    logic        Sign;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] Product;
    logic        Busy;

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb_q[$];

    pipelined_booth_multiplier #(.WIDTH(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .InValid      (InValid),
        .InReady      (InReady),
        .Multiplier   (Multiplier),
        .Multiplicand (Multiplicand),
        .Sign         (Sign),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .Product      (Product),
        .Busy         (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'd0, a};
        eb = s ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // BUSY cycles from acceptance to DONE for a given multiplier.
    function automatic int exp_latency(input logic [31:0] a, input logic s);
`ifdef BOOTH_MULT_EARLY_TERM_EN
        logic [33:0] m;
        logic [33:0] mask;
        logic [33:0] up;
        m = s ? {{2{a[31]}}, a} : {2'b00, a};
        for (int i = 0; i < 17; i++) begin
            mask = (34'd1 << (33 - 2 * i)) - 34'd1;
            up   = (m >> (2 * i + 1)) & mask;
            if (up == 34'd0 || up == mask) return i + 1;
        end
        return 17;
`else
        if (s && a == 32'd0) return 17;  // keeps both arguments referenced
        return 17;
`endif
    endfunction

    task automatic test_reset();
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        Multiplier = '0; Multiplicand = '0; Sign = 1'b0;
        step(); step();
        Reset = 1'b0;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Busy !== 1'b0 || Product !== 64'd0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b prod=%h, want 1 0 0 0",
                     InReady, OutValid, Busy, Product);
        end
    endtask

    // One full operation; hold = cycles OutReady stays low after OutValid rises.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int hold, input string name);
        int          n;
        logic [63:0] e;
        logic [63:0] first;
        n = 0;
        while (!InReady && n < 50) begin step(); n++; end
        checks++;
        if (InReady !== 1'b1) begin
            failures++;
            $display("FAIL %s_inready: got %b want 1", name, InReady);
        end
        Multiplier = a; Multiplicand = b; Sign = s; InValid = 1'b1;
        sb_q.push_back(exp);
        step();
        InValid = 1'b0; Multiplier = $urandom; Multiplicand = $urandom; Sign = ~s;
        checks++;
        if (Busy !== 1'b1 || InReady !== 1'b0) begin
            failures++;
            $display("FAIL %s_busy: got busy=%b rdy=%b want 1 0", name, Busy, InReady);
        end
        n = 0;
        while (OutValid !== 1'b1 && n < 60) begin step(); n++; end
        checks++;
        if (n !== exp_latency(a, s)) begin
            failures++;
            $display("FAIL %s_latency: got %0d want %0d", name, n, exp_latency(a, s));
        end
        first = Product;
        for (int i = 0; i < hold; i++) begin
            InValid = 1'b1;
            step();
            checks++;
            if (OutValid !== 1'b1 || InReady !== 1'b0 || Product !== first) begin
                failures++;
                $display("FAIL %s_hold: cyc %0d got vld=%b rdy=%b prod=%h want 1 0 %h",
                         name, i, OutValid, InReady, Product, first);
            end
        end
        InValid = 1'b0;
        e = sb_q.size() > 0 ? sb_q.pop_front() : 64'd0;
        checks++;
        if (Product !== e || OutValid !== 1'b1) begin
            failures++;
            $display("FAIL %s_product: got %h vld=%b want %h", name, Product, OutValid, e);
        end
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Product !== e) begin
            failures++;
            $display("FAIL %s_exit: got rdy=%b vld=%b prod=%h want 1 0 %h",
                     name, InReady, OutValid, Product, e);
        end
    endtask

    task automatic test_directed();
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, "uns_max");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, "sgn_min");
        run_op(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 0, "sgn_neg1");
        run_op(32'd3, 32'd7, 1'b0, 64'd21, 0, "small");
        run_op(32'd0, 32'hDEAD_BEEF, 1'b0, 64'd0, 0, "zero");
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, 0, "sgn_mix");
    endtask

    task automatic test_backpressure();
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 64'h0B00_EA4E_242D_2080, 10, "bp");
    endtask

    task automatic test_reset_mid_op();
        int seen;
        Multiplier = 32'h0000_00FF; Multiplicand = 32'h0000_0101; Sign = 1'b0; InValid = 1'b1;
        step();
        InValid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0 || Product !== 64'd0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: got rdy=%b vld=%b busy=%b prod=%h want 1 0 0 0",
                     InReady, OutValid, Busy, Product);
        end
        seen = 0;
        OutReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (OutValid === 1'b1) seen++;
            step();
        end
        OutReady = 1'b0;
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL rst_no_result: got %0d valid cycles want 0", seen);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random(input int nops);
        int          accepted;
        int          cycles;
        int          mism;
        logic        holding;
        logic [63:0] held;
        logic [63:0] e;
        accepted = 0; cycles = 0; mism = 0; holding = 1'b0; held = '0;
        while ((accepted < nops || sb_q.size() > 0) && cycles < 90000) begin
            if (holding && (OutValid !== 1'b1 || Product !== held)) begin
                mism++;
                if (mism < 5)
                    $display("FAIL rand_stable: got vld=%b prod=%h want 1 %h",
                             OutValid, Product, held);
            end
            InValid      = (accepted < nops) && ($urandom_range(0, 3) != 0);
            Multiplier   = pick_operand();
            Multiplicand = pick_operand();
            Sign         = $urandom_range(0, 1) == 1;
            OutReady     = $urandom_range(0, 2) != 0;
            if (InValid && InReady) begin
                sb_q.push_back(ref_mul(Multiplier, Multiplicand, Sign));
                accepted++;
            end
            holding = 1'b0;
            if (OutValid === 1'b1) begin
                if (OutReady) begin
                    e = sb_q.size() > 0 ? sb_q.pop_front() : 64'hX;
                    checks++;
                    if (Product !== e) begin
                        failures++;
                        if (failures < 10)
                            $display("FAIL rand_product: got %h want %h", Product, e);
                    end
                end else begin
                    holding = 1'b1;
                    held    = Product;
                end
            end
            step();
            cycles++;
        end
        InValid = 1'b0; OutReady = 1'b0;
        checks++;
        if (sb_q.size() !== 0 || accepted !== nops) begin
            failures++;
            $display("FAIL rand_drain: got %0d pending %0d accepted want 0 %0d",
                     sb_q.size(), accepted, nops);
        end
        checks++;
        if (mism !== 0) begin
            failures++;
            $display("FAIL rand_hold: got %0d unstable cycles want 0", mism);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
        test_random(2000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
